// File: rtl/nvb_led_ctrl.sv
// Switch/button-to-LED controller: synchronised, debounced buttons drive a four-mode display
// (mirror, rotating marquee, up/down counter, held snapshot) with a prescaled step tick.
module nvb_led_ctrl #(
  parameter int unsigned SW_W       = 8,
  parameter int unsigned LED_W      = 16,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned STEP_DIV   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       btn,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] ledr,
  output logic [1:0]       mode,
  output logic             paused,
  output logic             dir
);

  localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PreW = $clog2(STEP_DIV);

  typedef enum logic [1:0] {
    StMirror = 2'd0,
    StShift  = 2'd1,
    StCount  = 2'd2,
    StHold   = 2'd3
  } mode_e;

  logic [4:0]      sync1_q, sync2_q, stable_q, stable_dly_q, press_q;
  logic [DebW-1:0] deb_cnt_q [5];

  mode_e            mode_q;
  logic             paused_q, dir_q;
  logic [LED_W-1:0] pattern_q, counter_q, snap_q, ledr_q;
  logic [PreW-1:0]  presc_q;

  logic             tick;
  logic [LED_W-1:0] mirror, sw_ext, sw_load;

  // Press pulse fires the cycle after stable rises, so it lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          stable_q[i]  <= ~stable_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < LED_W; g++) begin : g_mirror
    assign mirror[g] = sw[g % SW_W];
  end

  assign sw_ext  = LED_W'(sw);
  assign sw_load = (sw == '0) ? LED_W'(1) : sw_ext;
  assign tick    = (presc_q == PreW'(STEP_DIV - 1));

  // Priority: mode change > clear > reload > tick; pause/dir toggles are independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= StMirror;
      paused_q  <= 1'b0;
      dir_q     <= 1'b0;
      pattern_q <= '0;
      counter_q <= '0;
      snap_q    <= '0;
      presc_q   <= '0;
      ledr_q    <= '0;
    end else begin
      if (press_q[1]) paused_q <= ~paused_q;
      if (press_q[2]) dir_q <= ~dir_q;

      presc_q <= (press_q[0] || tick) ? '0 : presc_q + 1'b1;

      if (press_q[0]) begin
        unique case (mode_q)
          StMirror: begin
            mode_q    <= StShift;
            pattern_q <= sw_load;
          end
          StShift: mode_q <= StCount;
          StCount: begin
            mode_q <= StHold;
            snap_q <= sw_ext;
          end
          StHold:  mode_q <= StMirror;
          default: mode_q <= StMirror;
        endcase
      end else if (press_q[4]) begin
        pattern_q <= '0;
        counter_q <= '0;
        snap_q    <= '0;
      end else if (press_q[3]) begin
        case (mode_q)
          StShift: pattern_q <= sw_load;
          StCount: counter_q <= sw_ext;
          StHold:  snap_q    <= sw_ext;
          default: ;
        endcase
      end else if (tick && !paused_q) begin
        case (mode_q)
          StShift: pattern_q <= dir_q ? {pattern_q[0], pattern_q[LED_W-1:1]}
                                      : {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
          StCount: counter_q <= dir_q ? counter_q - 1'b1 : counter_q + 1'b1;
          default: ;
        endcase
      end

      unique case (mode_q)
        StMirror: ledr_q <= mirror;
        StShift:  ledr_q <= pattern_q;
        StCount:  ledr_q <= counter_q;
        StHold:   ledr_q <= snap_q;
        default:  ledr_q <= '0;
      endcase
    end
  end

  assign ledr   = ledr_q;
  assign mode   = mode_q;
  assign paused = paused_q;
  assign dir    = dir_q;

endmodule
